// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / return-stack unit: op width and pc_ctl encodings.
package pc_pkg;

  localparam int PC_OP_W = 3;

  localparam logic [PC_OP_W-1:0] PC_OP_INC  = 3'd0;
  localparam logic [PC_OP_W-1:0] PC_OP_HOLD = 3'd1;
  localparam logic [PC_OP_W-1:0] PC_OP_BR   = 3'd2;
  localparam logic [PC_OP_W-1:0] PC_OP_BRC  = 3'd3;
  localparam logic [PC_OP_W-1:0] PC_OP_JR   = 3'd4;
  localparam logic [PC_OP_W-1:0] PC_OP_CALL = 3'd5;
  localparam logic [PC_OP_W-1:0] PC_OP_RET  = 3'd6;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO with occupancy pointer 0..STACK_DEPTH; push while full and
// pop while empty are ignored here, so the stack contents never change on a misuse.
module pc_ras #(
  parameter int DATA_BITS   = 6,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clka,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] push_data,
  output logic [DATA_BITS-1:0] top_data,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_BITS = $clog2(STACK_DEPTH + 1);
  localparam int IDX_BITS = $clog2(STACK_DEPTH);

  logic [PTR_BITS-1:0]  ptr_q, ptr_d;
  logic [DATA_BITS-1:0] mem_q [STACK_DEPTH];
  logic [IDX_BITS-1:0]  wr_idx, rd_idx;

  assign full     = (ptr_q == PTR_BITS'(STACK_DEPTH));
  assign empty    = (ptr_q == '0);
  assign wr_idx   = IDX_BITS'(ptr_q);
  assign rd_idx   = IDX_BITS'(ptr_q - PTR_BITS'(1));
  assign top_data = mem_q[rd_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (push && !full) begin
      ptr_d = ptr_q + PTR_BITS'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PTR_BITS'(1);
    end
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Entries need no reset: only the pointer decides what is observable.
  always_ff @(posedge clka) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with next-PC mux and sticky stack error flag. The return-address stack
// is built only when PC_CALL_STACK_EN is defined; otherwise CALL acts as BR and RET as INC.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int                 PC_BITS     = 6,
  parameter int                 REG_BITS    = 8,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [PC_BITS-1:0] RESET_PC    = '0
) (
  input  logic                clka,
  input  logic                reset,
  input  logic                pc_latch_data,
  input  logic [PC_OP_W-1:0]  pc_ctl,
  input  logic [PC_BITS-1:0]  imm,
  input  logic [REG_BITS-1:0] sr1_val,
  input  logic                br_cond,
  output logic [PC_BITS-1:0]  pc_out,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                stack_err
);

  if (STACK_DEPTH < 2 || STACK_DEPTH > 16) begin : g_bad_depth
    $error("pc_stack_unit: STACK_DEPTH must be in 2..16");
  end

  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [PC_BITS-1:0] pc_inc;
  logic [PC_BITS-1:0] jr_target;
  logic [PC_BITS-1:0] ret_target;

  assign pc_inc    = pc_q + PC_BITS'(1);
  assign jr_target = PC_BITS'(sr1_val);
  assign pc_out    = pc_q;

`ifdef PC_CALL_STACK_EN
  logic               is_call, is_ret;
  logic               ras_full, ras_empty;
  logic [PC_BITS-1:0] ras_top;
  logic               err_q, err_d;

  assign is_call = pc_latch_data && (pc_ctl == PC_OP_CALL);
  assign is_ret  = pc_latch_data && (pc_ctl == PC_OP_RET);

  pc_ras #(
    .DATA_BITS  (PC_BITS),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ras (
    .clka     (clka),
    .reset    (reset),
    .push     (is_call),
    .pop      (is_ret),
    .push_data(pc_inc),
    .top_data (ras_top),
    .full     (ras_full),
    .empty    (ras_empty)
  );

  // An empty-stack RET falls through to the next instruction.
  assign ret_target = ras_empty ? pc_inc : ras_top;
  assign err_d      = err_q | (is_call && ras_full) | (is_ret && ras_empty);

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign stack_full  = ras_full;
  assign stack_empty = ras_empty;
  assign stack_err   = err_q;
`else
  assign ret_target  = pc_inc;
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign stack_err   = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    case (pc_ctl)
      PC_OP_INC:  pc_d = pc_inc;
      PC_OP_HOLD: pc_d = pc_q;
      PC_OP_BR:   pc_d = imm;
      PC_OP_BRC:  pc_d = br_cond ? imm : pc_inc;
      PC_OP_JR:   pc_d = jr_target;
      PC_OP_CALL: pc_d = imm;
      PC_OP_RET:  pc_d = ret_target;
      default:    pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (pc_latch_data) begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 SHALL have parameter PC_BITS, default 6: program-counter width.
REQ-002 SHALL have parameter REG_BITS, default 8: register-operand width for indirect jumps.
REQ-003 SHALL have parameter STACK_DEPTH, default 4, legal range 2..16: return-address-stack entries.
REQ-004 SHALL have parameter RESET_PC, default 0: pc_out value after reset.
REQ-005 SHALL have port clka, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port pc_latch_data, input, 1 bit: update enable; when 0, all state holds.
REQ-008 SHALL have port pc_ctl, input, 3 bits: operation select.
REQ-009 SHALL have port imm, input, PC_BITS bits: absolute branch or call target.
REQ-010 SHALL have port sr1_val, input, REG_BITS bits: indirect jump target.
REQ-011 SHALL have port br_cond, input, 1 bit: condition for conditional branch.
REQ-012 SHALL have port pc_out, output, PC_BITS bits: current program counter, registered.
REQ-013 SHALL have ports stack_full and stack_empty, outputs, 1 bit each: stack occupancy flags.
REQ-014 SHALL have port stack_err, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-015 pc_ctl encodings SHALL be: 0 INC, 1 HOLD, 2 BR (pc<=imm), 3 BRC (pc<=imm if br_cond, else pc+1), 4 JR (pc<=sr1_val), 5 CALL, 6 RET, 7 reserved (treated as HOLD).
REQ-016 State SHALL change only on a rising clka edge with pc_latch_data=1; latency is one cycle, and pc_out reflects the new value immediately after the edge.
REQ-017 All PC arithmetic SHALL be modulo 2^PC_BITS; for example, INC at 2^PC_BITS-1 wraps to 0.
REQ-018 JR SHALL zero-extend sr1_val when REG_BITS<PC_BITS and SHALL truncate to the low PC_BITS bits otherwise.
REQ-019 CALL SHALL push pc+1 (wrapped) onto the stack and load imm into pc in the same cycle.
REQ-020 RET SHALL pop the top entry into pc.
REQ-021 CALL while stack_full SHALL perform no push and leave stack contents unchanged, SHALL still load imm into pc, and SHALL set stack_err.
REQ-022 RET while stack_empty SHALL load pc+1 into pc, leave the stack unchanged, and set stack_err.
REQ-023 stack_err SHALL remain set until reset.
REQ-024 The stack SHALL be LIFO with a pointer 0..STACK_DEPTH.
REQ-025 stack_full SHALL be 1 when pointer=STACK_DEPTH, and stack_empty SHALL be 1 when pointer=0; both flags are registered-state-derived.
REQ-026 The stack and flags SHALL change only on CALL or RET.

Reset
REQ-027 Asserting reset SHALL immediately, without waiting for a clock edge, set pc_out=RESET_PC, pointer=0, stack_empty=1, stack_full=0 and stack_err=0.
REQ-028 Reset SHALL override pc_latch_data, and reset asserted mid-sequence SHALL discard all stacked return addresses.
REQ-029 The first update SHALL occur on the first rising clka edge after reset deasserts with pc_latch_data=1.
REQ-030 Stack entry contents after reset SHALL be don't-care and never observable.

Configuration
REQ-031 Macro PC_CALL_STACK_EN SHALL control the return-address stack; when defined, the stack behaves per REQ-019..REQ-026.
REQ-032 When PC_CALL_STACK_EN is undefined: no stack storage is built; CALL behaves as BR; RET behaves as INC; stack_empty is tied to 1, stack_full to 0 and stack_err to 0.

Structure
REQ-033 Shared package pc_pkg SHALL hold the pc_ctl encoding constants (PC_OP_INC..PC_OP_RET) and the 3-bit op width constant.
REQ-034 The stack SHALL be a sub-module pc_ras (clka, reset, push, pop, push_data, top_data, full, empty), instantiated only under PC_CALL_STACK_EN.
REQ-035 The pc_stack_unit top SHALL hold the PC register, next-PC multiplexer and error flag.

Verification
REQ-036 Reset/INC: reset pulse, then 70 INC cycles with PC_BITS=6 -> pc_out counts 0..63, wraps to 0 at cycle 64 and reaches 6 at cycle 70; no flag changes.
REQ-037 BR/BRC/JR/HOLD: pc=5, BR imm=20 -> 20; BRC imm=40 br_cond=0 -> 21; BRC br_cond=1 -> 40; JR sr1_val=8'hFF -> 63; HOLD -> 63; pc_latch_data=0 with BR -> 63.
REQ-038 Nested calls: pc=10, CALL imm=30 -> 30; CALL imm=50 -> 50; RET -> 31; RET -> 11 with stack_empty=1.
REQ-039 Overflow/underflow: 5 CALLs with STACK_DEPTH=4 -> stack_full=1 after the 4th and stack_err=1 after the 5th; 4 RETs return the first 4 pushes in reverse order; a 5th RET gives pc+1 with stack_err still 1.
REQ-040 Asynchronous reset mid-stack: after 2 CALLs, assert reset between edges -> pc_out=RESET_PC and stack_empty=1 before the next edge; a following RET -> pc=RESET_PC+1 and stack_err=1.
REQ-041 Macro off: build without PC_CALL_STACK_EN -> CALL imm=12 gives pc=12; RET gives 13; flags read 1/0/0 throughout.
